// File: rtl/quadrature_pkg.sv
// Shared widths, defaults and Gray-state encoding for the quadrature decoder.
// gray_fwd() gives the next state in the forward rotation 00->01->11->10->00.
package quadrature_pkg;

    localparam int POSITION_WIDTH      = 13;
    localparam int ELEC_WIDTH          = 11;
    localparam int ELEC_PERIOD_DEFAULT = 1170;
    localparam int FILTER_LEN_DEFAULT  = 3;

    typedef enum logic [1:0] {
        GRAY_00 = 2'b00,
        GRAY_01 = 2'b01,
        GRAY_11 = 2'b11,
        GRAY_10 = 2'b10
    } gray_state_e;

    function automatic gray_state_e gray_fwd(input gray_state_e s);
        case (s)
            GRAY_00: return GRAY_01;
            GRAY_01: return GRAY_11;
            GRAY_11: return GRAY_10;
            default: return GRAY_00;
        endcase
    endfunction

endpackage

// File: rtl/input_filter.sv
// Two-flop synchronizer followed by a stability filter: o_level follows the pin
// only after FILTER_LEN equal consecutive synchronized samples; o_valid marks the first accepted level.
module input_filter
    import quadrature_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_valid
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_fill;
    logic          r_cand;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;

    always_comb begin
        // NOTE: default first so every path assigns w_next_cnt and no latch is inferred.
        w_next_cnt = r_cnt;
        if (r_sync2 != r_cand) begin
            w_next_cnt = CW'(1);
        end else if (r_cnt < CW'(FILTER_LEN)) begin
            w_next_cnt = r_cnt + 1'b1;
        end
    end

    // r_fill keeps post-reset zeros still inside the synchronizer from counting as samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_fill  <= 2'b00;
            r_cand  <= 1'b0;
            r_cnt   <= '0;
            o_level <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so the two flops form a real shift chain, not one wire.
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1]) begin
                r_cand <= r_sync2;
                r_cnt  <= w_next_cnt;
                if (w_next_cnt == CW'(FILTER_LEN)) begin
                    o_level <= r_sync2;
                    o_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B/index feed a one-stage pipeline, then a decode
// stage updates a 13-bit mechanical count and a modulo-ELEC_PERIOD electrical count.
module quadrature_decoder
    import quadrature_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEFAULT,
    parameter int ELEC_PERIOD = ELEC_PERIOD_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enc_a,
    input  logic                      enc_b,
    input  logic                      enc_index,
    input  logic                      index_zero_en,
    input  logic                      clear,
    input  logic                      illegal_clear,
    output logic [POSITION_WIDTH-1:0] position,
    output logic [ELEC_WIDTH-1:0]     elec_angle,
    output logic                      direction,
    output logic                      step_valid,
    output logic                      illegal_transition
);

    logic w_a, w_b, w_idx;
    logic w_a_valid, w_b_valid, w_idx_valid;

    input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .i_pin(enc_a), .o_level(w_a), .o_valid(w_a_valid)
    );
    input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .i_pin(enc_b), .o_level(w_b), .o_valid(w_b_valid)
    );
    input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_idx (
        .clk(clk), .reset(reset), .i_pin(enc_index), .o_level(w_idx), .o_valid(w_idx_valid)
    );

    gray_state_e r_ab;
    gray_state_e r_ref;
    logic        r_ab_valid;
    logic        r_primed;
    logic        r_idx;
    logic        r_idx_valid;
    logic        r_idx_prev;
    logic        r_idx_prev_valid;

    logic                  w_decode;
    logic                  w_fwd;
    logic                  w_rev;
    logic                  w_illegal;
    logic                  w_index_zero;
    logic [ELEC_WIDTH-1:0] w_elec_inc;
    logic [ELEC_WIDTH-1:0] w_elec_dec;

    always_comb begin
        w_decode     = r_primed && r_ab_valid;
        w_fwd        = w_decode && (r_ab == gray_fwd(r_ref));
        w_rev        = w_decode && (gray_fwd(r_ab) == r_ref);
        w_illegal    = w_decode && ((r_ab ^ r_ref) == 2'b11);
        w_index_zero = index_zero_en && r_idx && !r_idx_prev && r_idx_prev_valid;
        w_elec_inc   = (elec_angle == ELEC_WIDTH'(ELEC_PERIOD - 1)) ? '0 : elec_angle + 1'b1;
        w_elec_dec   = (elec_angle == '0) ? ELEC_WIDTH'(ELEC_PERIOD - 1) : elec_angle - 1'b1;
    end

    // The first valid {A,B} becomes r_ref with r_primed still low, so it never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ab               <= GRAY_00;
            r_ref              <= GRAY_00;
            r_ab_valid         <= 1'b0;
            r_primed           <= 1'b0;
            r_idx              <= 1'b0;
            r_idx_valid        <= 1'b0;
            r_idx_prev         <= 1'b0;
            r_idx_prev_valid   <= 1'b0;
            position           <= '0;
            elec_angle         <= '0;
            direction          <= 1'b0;
            step_valid         <= 1'b0;
            illegal_transition <= 1'b0;
        end else begin
            r_ab             <= gray_state_e'({w_a, w_b});
            r_ab_valid       <= w_a_valid && w_b_valid;
            r_idx            <= w_idx;
            r_idx_valid      <= w_idx_valid;
            r_idx_prev       <= r_idx;
            r_idx_prev_valid <= r_idx_valid;

            if (r_ab_valid) begin
                r_ref <= r_ab;
            end
            r_primed   <= r_primed || r_ab_valid;
            step_valid <= w_fwd || w_rev;
            if (w_fwd || w_rev) begin
                direction <= w_fwd;
            end

            // Clear and index zeroing override a coincident step's count but not its pulse.
            if (clear || w_index_zero) begin
                position   <= '0;
                elec_angle <= '0;
            end else if (w_fwd) begin
                position   <= position + 1'b1;
                elec_angle <= w_elec_inc;
            end else if (w_rev) begin
                position   <= position - 1'b1;
                elec_angle <= w_elec_dec;
            end

            if (w_illegal) begin
                illegal_transition <= 1'b1;
            end else if (illegal_clear) begin
                illegal_transition <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized self-checking bench: an abstract encoder phase drives the pins and a
// modular-arithmetic model predicts counts, direction, latency and the error flag.
module tb_quadrature_decoder;

    localparam int FL   = 3;
    localparam int EP   = 1170;
    localparam int PMOD = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        enc_a, enc_b, enc_index;
    logic        index_zero_en, clear, illegal_clear;
    logic [12:0] position;
    logic [10:0] elec_angle;
    logic        direction, step_valid, illegal_transition;

    quadrature_decoder #(.FILTER_LEN(FL), .ELEC_PERIOD(EP)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_index(enc_index),
        .index_zero_en(index_zero_en), .clear(clear), .illegal_clear(illegal_clear),
        .position(position), .elec_angle(elec_angle), .direction(direction),
        .step_valid(step_valid), .illegal_transition(illegal_transition)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sv_count = 0;

    // Model state: encoder phase in the forward rotation plus expected outputs.
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int m_phase, m_pos, m_elec, m_dir, m_ill;

    always @(negedge clk) if (step_valid === 1'b1) sv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pos"}, 32'(position), 32'(m_pos));
        check({tag, "_elec"}, 32'(elec_angle), 32'(m_elec));
        check({tag, "_dir"}, 32'(direction), 32'(m_dir));
    endtask

    function automatic void model_step(input bit fwd);
        if (fwd) begin
            m_pos  = (m_pos + 1) % PMOD;
            m_elec = (m_elec + 1) % EP;
        end else begin
            m_pos  = (m_pos + PMOD - 1) % PMOD;
            m_elec = (m_elec + EP - 1) % EP;
        end
        m_dir = fwd ? 1 : 0;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(3);
        check("rst_outputs", {19'd0, position, elec_angle, direction, step_valid, illegal_transition}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_pos = 0; m_elec = 0; m_dir = 0; m_ill = 0;
    endtask

    // One encoder step; with chk set, step_valid must rise exactly FL+3 edges after E0.
    task automatic do_step(input bit fwd, input int gap, input bit chk);
        m_phase = fwd ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
        @(negedge clk);
        {enc_a, enc_b} = gray_tab[m_phase];
        for (int k = 1; k <= gap; k++) begin
            @(posedge clk);
            #1;
            if (chk && k == FL + 3) check("lat_early", 32'(step_valid), 32'd0);
            if (chk && k == FL + 4) check("lat_pulse", 32'(step_valid), 32'd1);
        end
        model_step(fwd);
        if (chk) check_counts("step");
    endtask

    // Forward step with an index rise on the same edge, zeroed by index or by clear.
    task automatic index_step(input bit use_clear);
        m_phase = (m_phase + 1) % 4;
        @(negedge clk);
        {enc_a, enc_b} = gray_tab[m_phase];
        enc_index     = 1'b1;
        index_zero_en = !use_clear;
        wait_cycles(FL + 3);
        @(negedge clk);
        clear = use_clear;
        @(posedge clk);
        #1;
        check(use_clear ? "clr_idx_sv" : "idx_sv", 32'(step_valid), 32'd1);
        m_pos = 0; m_elec = 0; m_dir = 1;
        check_counts(use_clear ? "clr_idx" : "idx");
        @(negedge clk);
        clear = 1'b0;
        wait_cycles(6);
        @(negedge clk);
        enc_index = 1'b0;
        wait_cycles(12);
        index_zero_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv_before;
        reset = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enc_index = 1'b0;
        index_zero_en = 1'b0; clear = 1'b0; illegal_clear = 1'b0;
        m_phase = 2;

        // Reset with A=B=1: priming must not count.
        do_reset();
        wait_cycles(20);
        check("prime_no_step", 32'(sv_count), 32'd0);
        check_counts("prime");

        for (int i = 0; i < 4; i++) do_step(1'b1, 10, 1'b1);
        check("four_fwd_pos", 32'(position), 32'd4);
        check("four_fwd_elec", 32'(elec_angle), 32'd4);

        // Clear, then reverse from zero wraps both counters.
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        m_pos = 0; m_elec = 0;
        check_counts("clear");
        do_step(1'b0, 10, 1'b1);
        check("rev_wrap_pos", 32'(position), 32'd8191);
        check("rev_wrap_elec", 32'(elec_angle), 32'd1169);
        do_step(1'b1, 10, 1'b1);

        // Long forward runs: electrical wrap, then mechanical wrap.
        for (int i = 0; i < 1170; i++) do_step(1'b1, FL + 5, 1'b0);
        check_counts("run1170");
        check("run1170_elec", 32'(elec_angle), 32'd0);
        for (int i = 0; i < 7022; i++) do_step(1'b1, FL + 5, 1'b0);
        check_counts("run8192");
        check("run8192_elec", 32'(elec_angle), 32'd2);

        // Randomized direction and spacing.
        for (int i = 0; i < 150; i++) do_step(1'($urandom_range(0, 1)), $urandom_range(FL + 4, 12), 1'b1);

        // Glitch shorter than the filter length.
        sv_before = sv_count;
        @(negedge clk); enc_a = ~enc_a;
        wait_cycles(1);
        @(negedge clk); enc_a = ~enc_a;
        wait_cycles(20);
        check("glitch_sv", 32'(sv_count), 32'(sv_before));
        check_counts("glitch");

        // Double-edge transition sets the sticky flag without counting.
        m_phase = (m_phase + 2) % 4;
        @(negedge clk); {enc_a, enc_b} = gray_tab[m_phase];
        wait_cycles(20);
        check("illegal_set", 32'(illegal_transition), 32'd1);
        check("illegal_sv", 32'(sv_count), 32'(sv_before));
        check_counts("illegal");

        // Second illegal transition coinciding with illegal_clear keeps the flag set.
        m_phase = (m_phase + 2) % 4;
        @(negedge clk); {enc_a, enc_b} = gray_tab[m_phase];
        wait_cycles(FL + 3);
        @(negedge clk); illegal_clear = 1'b1;
        @(posedge clk); #1;
        check("illegal_vs_clear", 32'(illegal_transition), 32'd1);
        @(negedge clk); illegal_clear = 1'b0;
        wait_cycles(4);
        @(negedge clk); illegal_clear = 1'b1;
        @(negedge clk); illegal_clear = 1'b0;
        check("illegal_cleared", 32'(illegal_transition), 32'd0);

        // Index rise with zeroing disabled has no effect on the counts.
        do_step(1'b1, 10, 1'b1);
        do_step(1'b1, 10, 1'b1);
        @(negedge clk); enc_index = 1'b1;
        wait_cycles(12);
        @(negedge clk); enc_index = 1'b0;
        wait_cycles(12);
        check_counts("idx_disabled");

        index_step(1'b0);
        do_step(1'b1, 10, 1'b1);
        do_step(1'b1, 10, 1'b1);
        index_step(1'b1);

        // Reset two cycles after an A/B edge discards the step.
        do_step(1'b1, 10, 1'b1);
        sv_before = sv_count;
        m_phase = (m_phase + 1) % 4;
        @(negedge clk); {enc_a, enc_b} = gray_tab[m_phase];
        @(posedge clk); @(posedge clk);
        do_reset();
        wait_cycles(30);
        check("midstep_rst_sv", 32'(sv_count), 32'(sv_before));
        check("midstep_rst_out", {19'd0, position, elec_angle, direction, step_valid, illegal_transition}, 32'd0);

        // Counting resumes normally after re-priming.
        do_step(1'b0, 10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
